instruction_fetch: RTL and testbench

Fetch stage directly upstream of the instruction decoder. Holds the program counter and issues word reads to instruction memory over a req/ready handshake. Presents each returned word with a one-cycle `decode_enable` pulse on the decoder's `instruction`/`enable` inputs. Handles decode stalls and taken-branch redirects from execute, so a wrong-path word never reaches decode.

---
 rtl/arm_cpu_pkg.sv | 16 +
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_cpu_pkg.sv
// Shared definitions for the ARM CPU pipeline: fetch FSM states, word size and
// the default boot address.
package arm_cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] WORD_BYTES           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] PC_READ_AHEAD        = 32'd8;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory over req/ready and hands
// words to decode. Define FETCH_PC8_EN to tag words with fetch address + 8.
module instruction_fetch
   import arm_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc_out,
   output logic        decode_enable
);

`ifdef FETCH_PC8_EN
   localparam logic [31:0] TAG_OFFSET = PC_READ_AHEAD;
`else
   localparam logic [31:0] TAG_OFFSET = 32'd0;
`endif

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_addr_q, w_addr_nxt;
   logic [31:0]  r_instruction, w_instr_nxt;
   logic [31:0]  r_pc_out, w_pc_out_nxt;
   logic         r_decode_enable, w_de_nxt;

   logic [31:0]  w_target;
   logic [31:0]  w_pc_inc;

   assign w_target = branch_target & ~32'h0000_0003;
   assign w_pc_inc = r_pc + WORD_BYTES;

   // NOTE: every signal gets its hold value before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_addr_nxt   = r_addr_q;
      w_instr_nxt  = r_instruction;
      w_pc_out_nxt = r_pc_out;
      w_de_nxt     = 1'b0;

      case (r_state)
         IDLE: begin
            if (branch_taken) begin
               w_pc_nxt = w_target;
            end else if (!stall) begin
               w_addr_nxt  = r_pc;
               w_state_nxt = BUSY;
            end
         end

         BUSY: begin
            if (imem_ready && branch_taken) begin
               w_pc_nxt    = w_target;
               w_state_nxt = IDLE;
            end else if (imem_ready) begin
               w_instr_nxt  = imem_rdata;
               w_pc_out_nxt = r_addr_q + TAG_OFFSET;
               w_pc_nxt     = w_pc_inc;
               if (stall) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_de_nxt   = 1'b1;
                  w_addr_nxt = w_pc_inc;
               end
            end else if (branch_taken) begin
               // The request cannot be withdrawn; its response is discarded in DRAIN.
               w_pc_nxt    = w_target;
               w_state_nxt = DRAIN;
            end
         end

         DRAIN: begin
            if (branch_taken) begin
               w_pc_nxt = w_target;
            end
            if (imem_ready) begin
               w_state_nxt = IDLE;
            end
         end

         HOLD: begin
            if (branch_taken) begin
               w_pc_nxt    = w_target;
               w_state_nxt = IDLE;
            end else if (!stall) begin
               w_de_nxt    = 1'b1;
               w_state_nxt = IDLE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so every register samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= IDLE;
         r_pc            <= RESET_VECTOR;
         r_addr_q        <= RESET_VECTOR;
         r_instruction   <= 32'd0;
         r_pc_out        <= 32'd0;
         r_decode_enable <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_pc            <= w_pc_nxt;
         r_addr_q        <= w_addr_nxt;
         r_instruction   <= w_instr_nxt;
         r_pc_out        <= w_pc_out_nxt;
         r_decode_enable <= w_de_nxt;
      end
   end

   assign imem_req      = (r_state == BUSY) || (r_state == DRAIN);
   assign imem_addr     = r_addr_q;
   assign instruction   = r_instruction;
   assign pc_out        = r_pc_out;
   assign decode_enable = r_decode_enable;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_instruction_fetch;

`ifdef FETCH_PC8_EN
   localparam logic [31:0] OFF = 32'd8;
`else
   localparam logic [31:0] OFF = 32'd0;
`endif
   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stall, branch_taken, imem_ready;
   logic [31:0] branch_target;
   logic        imem_req, decode_enable;
   logic [31:0] imem_addr, imem_rdata, instruction, pc_out;
   logic        mem_ident;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .instruction   (instruction),
      .pc_out        (pc_out),
      .decode_enable (decode_enable)
   );

   // Memory: returns the address itself (directed phase) or a scrambled word.
   assign imem_rdata = mem_ident ? imem_addr
                                 : ({imem_addr[15:0], ~imem_addr[31:16]} ^ 32'h5A3C_96E1);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding read, possibly doomed by a
   // branch, and at most one word parked waiting for decode.
   logic        m_valid = 1'b0;
   logic [31:0] m_pc, m_addr, m_instr, m_tag, m_tgt;
   logic        m_req, m_doomed, m_held, m_de;

   always @(posedge clk) begin
      m_tgt = branch_target & 32'hFFFF_FFFC;
      if (reset) begin
         m_valid = 1'b1;
         m_pc = RV; m_addr = RV; m_instr = 0; m_tag = 0;
         m_req = 0; m_doomed = 0; m_held = 0; m_de = 0;
      end else if (m_valid) begin
         m_de = 1'b0;
         if (m_held) begin
            if (branch_taken) begin
               m_held = 0; m_pc = m_tgt;
            end else if (!stall) begin
               m_held = 0; m_de = 1;
            end
         end else if (m_req && !m_doomed) begin
            if (imem_ready && branch_taken) begin
               m_req = 0; m_pc = m_tgt;
            end else if (imem_ready) begin
               m_instr = imem_rdata;
               m_tag   = m_addr + OFF;
               m_pc    = m_pc + 4;
               if (stall) begin
                  m_req = 0; m_held = 1;
               end else begin
                  m_de = 1; m_addr = m_pc;
               end
            end else if (branch_taken) begin
               m_doomed = 1; m_pc = m_tgt;
            end
         end else if (m_req) begin
            if (branch_taken) m_pc = m_tgt;
            if (imem_ready) begin
               m_req = 0; m_doomed = 0;
            end
         end else begin
            if (branch_taken) m_pc = m_tgt;
            else if (!stall) begin
               m_req = 1; m_addr = m_pc;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
         if (m_req) check("imem_addr", imem_addr, m_addr);
         check("decode_enable", {31'd0, decode_enable}, {31'd0, m_de});
         check("instruction", instruction, m_instr);
         check("pc_out", pc_out, m_tag);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
      imem_ready = 1; mem_ident = 1;
      tick(); tick();

      // Always-ready stream from the reset vector.
      reset = 0;
      tick();
      check("boot_req", {31'd0, imem_req}, 32'd1);
      check("boot_addr", imem_addr, 32'h0);
      check("boot_de0", {31'd0, decode_enable}, 32'd0);
      tick();
      check("boot_de1", {31'd0, decode_enable}, 32'd1);
      check("boot_instr0", instruction, 32'h0);
      check("boot_tag0", pc_out, 32'h0 + OFF);
      tick();
      check("boot_instr4", instruction, 32'h4);
      tick();
      check("boot_instr8", instruction, 32'h8);
      check("boot_tag8", pc_out, 32'h8 + OFF);

      // Late memory response at 0x10.
      reset = 1;
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_instr", instruction, 32'd0);
      tick();
      reset = 0; branch_taken = 1; branch_target = 32'h10; imem_ready = 0;
      tick();
      branch_taken = 0;
      tick();
      check("late_addr_a", imem_addr, 32'h10);
      tick();
      check("late_addr_b", imem_addr, 32'h10);
      tick();
      check("late_addr_c", imem_addr, 32'h10);
      check("late_no_de", {31'd0, decode_enable}, 32'd0);
      imem_ready = 1;
      tick();
      check("late_de", {31'd0, decode_enable}, 32'd1);
      check("late_instr", instruction, 32'h10);
      tick(); tick(); tick();
      check("pre_stall_addr", imem_addr, 32'h20);

      // Stall on word 0x20 for four cycles.
      stall = 1;
      tick();
      check("hold_de", {31'd0, decode_enable}, 32'd0);
      check("hold_instr", instruction, 32'h20);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      tick(); tick(); tick();
      check("hold_still", instruction, 32'h20);
      stall = 0;
      tick();
      check("release_de", {31'd0, decode_enable}, 32'd1);
      check("release_instr", instruction, 32'h20);
      tick();
      check("after_hold_addr", imem_addr, 32'h24);

      // Branch while a request at 0x40 is outstanding.
      for (int i = 0; i < 20 && imem_addr !== 32'h40; i++) tick();
      check("reach_0x40", imem_addr, 32'h40);
      imem_ready = 0; branch_taken = 1; branch_target = 32'h103;
      tick();
      check("drain_req", {31'd0, imem_req}, 32'd1);
      check("drain_addr", imem_addr, 32'h40);
      branch_taken = 0;
      tick();
      check("drain_addr2", imem_addr, 32'h40);
      imem_ready = 1;
      tick();
      check("drain_drop", {31'd0, decode_enable}, 32'd0);
      tick();
      check("redirect_addr", imem_addr, 32'h100);
      tick();
      check("redirect_instr", instruction, 32'h100);

      // Branch coincident with ready, then branch during HOLD.
      branch_taken = 1; branch_target = 32'h200;
      tick();
      check("coinc_no_de", {31'd0, decode_enable}, 32'd0);
      branch_taken = 0;
      tick();
      check("coinc_addr", imem_addr, 32'h200);
      tick();
      check("coinc_instr", instruction, 32'h200);
      stall = 1;
      tick();
      check("hold2_instr", instruction, 32'h204);
      stall = 0; branch_taken = 1; branch_target = 32'h300;
      tick();
      check("hold_br_no_de", {31'd0, decode_enable}, 32'd0);
      branch_taken = 0;
      tick();
      check("hold_br_addr", imem_addr, 32'h300);
      tick();
      check("hold_br_instr", instruction, 32'h300);

      // Reset mid-BUSY, then wrap at the top of the address space.
      imem_ready = 0; reset = 1;
      tick();
      check("midrst_req", {31'd0, imem_req}, 32'd0);
      check("midrst_de", {31'd0, decode_enable}, 32'd0);
      check("midrst_addr", imem_addr, RV);
      reset = 0; branch_taken = 1; branch_target = 32'hFFFF_FFFE;
      tick();
      branch_taken = 0; imem_ready = 1;
      tick();
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_instr", instruction, 32'hFFFF_FFFC);
      check("wrap_tag", pc_out, 32'hFFFF_FFFC + OFF);
      check("wrap_next_addr", imem_addr, 32'h0);
      tick();
      check("wrap_instr0", instruction, 32'h0);

      // Randomized traffic.
      mem_ident = 0;
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 199) == 0);
         stall         = ($urandom_range(0, 99) < 30);
         branch_taken  = ($urandom_range(0, 99) < 8);
         branch_target = $urandom;
         imem_ready    = ($urandom_range(0, 99) < 60);
         tick();
      end
      reset = 0; stall = 0; branch_taken = 0; imem_ready = 1;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
